// File: rtl/spi_slave_mp.sv
`timescale 1ns/1ps
// Multi-mode SPI slave: SCLK/MOSI/CS_N oversampled in clk_i, any CPOL/CPHA, parametrised word width
// and bit order, with frame start/end/error strobes and a saturating per-frame word count.
module spi_slave_mp #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          LSB_FIRST   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_n_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [WORD_WIDTH-1:0] tx_data_i,
  output logic                  tx_load_o,
  output logic                  rx_vld_o,
  output logic [WORD_WIDTH-1:0] rx_data_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  frame_err_o,
  output logic [CNT_WIDTH-1:0]  frame_words_o
);
  localparam int unsigned   BW       = $clog2(WORD_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

  // S_WAIT: after reset, a frame already in progress is ignored until CS_N is seen high
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, flush_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, cs_s, flushed;
  logic                   lead_edge, trail_edge;
  logic                   start_c, end_c, active_c, sample_c, shift_c, word_done_c;
  logic [BW-1:0]          bit_cnt;
  logic [WORD_WIDTH-1:0]  rx_sr, rx_next;
  logic [WORD_WIDTH-1:0]  tx_sr, tx_nxt;
  logic                   skip, skip_nxt, tx_bit_nxt;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign flushed = flush_sync[SYNC_STAGES-1];

  assign lead_edge  = (sclk_s != sclk_d) && (sclk_s != CPOL);
  assign trail_edge = (sclk_s != sclk_d) && (sclk_s == CPOL);

  assign active_c    = (state == S_ACTIVE) && !cs_s;
  assign sample_c    = active_c && (CPHA ? trail_edge : lead_edge);
  assign shift_c     = active_c && (CPHA ? lead_edge : trail_edge);
  assign word_done_c = sample_c && (bit_cnt == LAST_BIT);

  assign rx_next = LSB_FIRST ? {mosi_s, rx_sr[WORD_WIDTH-1:1]} : {rx_sr[WORD_WIDTH-2:0], mosi_s};

  // Frame sequencing on the synchronised chip select
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    end_c     = 1'b0;
    case (state)
      S_WAIT:   if (flushed && cs_s) state_nxt = S_IDLE;
      S_IDLE:   if (!cs_s) begin
                  state_nxt = S_ACTIVE;
                  start_c   = 1'b1;
                end
      S_ACTIVE: if (cs_s) begin
                  state_nxt = S_IDLE;
                  end_c     = 1'b1;
                end
      default:  state_nxt = S_WAIT;
    endcase
  end

  // A (re)load presents bit 0 directly, so the next shift edge is swallowed where it would skip it
  always_comb begin
    tx_nxt   = tx_sr;
    skip_nxt = skip;
    if (start_c) begin
      tx_nxt   = tx_data_i;
      skip_nxt = CPHA;
    end else if (word_done_c) begin
      tx_nxt   = tx_data_i;
      skip_nxt = 1'b1;
    end else if (shift_c) begin
      if (skip) skip_nxt = 1'b0;
      else      tx_nxt   = LSB_FIRST ? {1'b0, tx_sr[WORD_WIDTH-1:1]} : {tx_sr[WORD_WIDTH-2:0], 1'b0};
    end
    tx_bit_nxt = LSB_FIRST ? tx_nxt[0] : tx_nxt[WORD_WIDTH-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync     <= {SYNC_STAGES{CPOL}};
      mosi_sync     <= '0;
      cs_sync       <= '1;
      flush_sync    <= '0;
      sclk_d        <= CPOL;
      state         <= S_WAIT;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      skip          <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      tx_load_o     <= 1'b0;
      rx_vld_o      <= 1'b0;
      rx_data_o     <= '0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_err_o   <= 1'b0;
      frame_words_o <= '0;
    end else begin
      sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync       <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      flush_sync    <= {flush_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d        <= sclk_s;
      state         <= state_nxt;
      tx_sr         <= tx_nxt;
      skip          <= skip_nxt;
      spi_miso_oe_o <= (state_nxt == S_ACTIVE);
      spi_miso_o    <= (state_nxt == S_ACTIVE) && tx_bit_nxt;
      tx_load_o     <= start_c || word_done_c;
      rx_vld_o      <= word_done_c;
      frame_start_o <= start_c;
      frame_end_o   <= end_c;
      frame_err_o   <= end_c && (bit_cnt != '0);
      if (start_c || end_c) begin
        bit_cnt <= '0;
      end else if (sample_c) begin
        rx_sr   <= rx_next;
        bit_cnt <= word_done_c ? '0 : bit_cnt + BW'(1);
      end
      if (start_c) begin
        frame_words_o <= '0;
      end else if (word_done_c) begin
        rx_data_o <= rx_next;
        if (frame_words_o != '1) frame_words_o <= frame_words_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule
